// File: rtl/fpu_pkg.sv
// Shared definitions for the FPU scheduler: operand field widths, op codes,
// status bit positions and the scheduler state encoding.
package fpu_pkg;

  localparam int EXP_WIDTH    = 7;
  localparam int MANT_WIDTH   = 24;
  localparam int DATA_WIDTH   = 1 + EXP_WIDTH + MANT_WIDTH;
  localparam int STATUS_WIDTH = 4;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;

  localparam int ST_EXACT     = 0;
  localparam int ST_OVERFLOW  = 1;
  localparam int ST_UNDERFLOW = 2;
  localparam int ST_INEXACT   = 3;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_RESP = 2'd2
  } sched_state_t;

  // Only add and sub are sent to the FPU; anything else is answered locally.
  function automatic logic op_is_legal(input logic [1:0] op);
    return (op == OP_ADD) || (op == OP_SUB);
  endfunction

endpackage

// File: rtl/fpu_scheduler_rr_arb2.sv
// Two-way round-robin arbiter. A lone requester always wins; on a tie the
// requester that did not win last time is granted. Purely combinational.
module rr_arb2
  import fpu_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last_grant,
  output logic [1:0] grant
);

  // One-hot grant selection
  always_comb begin
    grant = 2'b00;
    case (req)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = last_grant ? 2'b01 : 2'b10;
      default: grant = 2'b00;
    endcase
  end

endmodule

// File: rtl/fpu_scheduler.sv
// Schedules two requesters onto one shared external FPU, one transaction at
// a time. Illegal ops are answered directly with rsp_err set.
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high; ready never depends on valid of the same channel except through
// arbitration in IDLE, and a response is held unchanged until taken.
module fpu_scheduler
  import fpu_pkg::*;
#(
  parameter int FPU_LATENCY = 1  // legal range 1..15
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [1:0]                   req_valid,
  output logic [1:0]                   req_ready,
  input  logic [1:0][DATA_WIDTH-1:0]   req_a,
  input  logic [1:0][DATA_WIDTH-1:0]   req_b,
  input  logic [1:0][1:0]              req_op,
  output logic [1:0]                   rsp_valid,
  input  logic [1:0]                   rsp_ready,
  output logic [DATA_WIDTH-1:0]        rsp_data,
  output logic [STATUS_WIDTH-1:0]      rsp_status,
  output logic                         rsp_err,
  output logic [DATA_WIDTH-1:0]        fpu_a,
  output logic [DATA_WIDTH-1:0]        fpu_b,
  output logic [1:0]                   fpu_op,
  input  logic [DATA_WIDTH-1:0]        fpu_data_in,
  input  logic [STATUS_WIDTH-1:0]      fpu_status_in,
  output logic                         busy,
  output logic [15:0]                  done_cnt,
  output logic [1:0]                   state_dbg
);

  // EXEC lasts FPU_LATENCY cycles; the counter runs down to zero.
  localparam logic [3:0] LAT_M1 = 4'(FPU_LATENCY - 1);

  sched_state_t state, state_nxt;

  logic                    last_grant;
  logic [3:0]              cnt;
  logic [DATA_WIDTH-1:0]   op_a, op_b;
  logic [1:0]              op_op;
  logic                    op_id;
  logic [DATA_WIDTH-1:0]   rsp_data_q;
  logic [STATUS_WIDTH-1:0] rsp_status_q;
  logic                    rsp_err_q;
  logic [15:0]             done_cnt_q;

  logic [1:0] grant;
  logic       accept;
  logic       accept_id;
  logic       accept_legal;
  logic       rsp_hs;

  rr_arb2 u_arb (
    .req        (req_valid),
    .last_grant (last_grant),
    .grant      (grant)
  );

  assign accept       = |(req_valid & req_ready);
  assign accept_id    = req_ready[1];
  assign accept_legal = op_is_legal(req_op[accept_id]);
  assign rsp_hs       = (state == S_RESP) && rsp_ready[op_id];

  // State register
  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (accept) state_nxt = accept_legal ? S_EXEC : S_RESP;
      S_EXEC: if (cnt == 4'd0) state_nxt = S_RESP;
      S_RESP: if (rsp_hs) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // FSM-driven outputs; reset masks ready so it wins over a same-cycle accept
  always_comb begin
    req_ready = 2'b00;
    rsp_valid = 2'b00;
    busy      = (state != S_IDLE);
    if (state == S_IDLE && !reset) req_ready = grant;
    if (state == S_RESP) rsp_valid = op_id ? 2'b10 : 2'b01;
  end

  // Transaction registers, latency counter, result capture and completion count
  always_ff @(posedge clk) begin
    if (reset) begin
      last_grant   <= 1'b1;
      cnt          <= 4'd0;
      op_a         <= '0;
      op_b         <= '0;
      op_op        <= 2'b00;
      op_id        <= 1'b0;
      rsp_data_q   <= '0;
      rsp_status_q <= '0;
      rsp_err_q    <= 1'b0;
      done_cnt_q   <= 16'd0;
    end else begin
      if (accept) begin
        op_a       <= req_a[accept_id];
        op_b       <= req_b[accept_id];
        op_op      <= req_op[accept_id];
        op_id      <= accept_id;
        last_grant <= accept_id;
        cnt        <= LAT_M1;
        if (!accept_legal) begin
          rsp_data_q   <= '0;
          rsp_status_q <= '0;
          rsp_err_q    <= 1'b1;
        end
      end else if (state == S_EXEC) begin
        if (cnt == 4'd0) begin
          rsp_data_q   <= fpu_data_in;
          rsp_status_q <= fpu_status_in;
          rsp_err_q    <= 1'b0;
        end else begin
          cnt <= cnt - 4'd1;
        end
      end
      if (rsp_hs) done_cnt_q <= done_cnt_q + 16'd1;
    end
  end

  assign fpu_a      = op_a;
  assign fpu_b      = op_b;
  assign fpu_op     = op_op;
  assign rsp_data   = rsp_data_q;
  assign rsp_status = rsp_status_q;
  assign rsp_err    = rsp_err_q;
  assign done_cnt   = done_cnt_q;
  assign state_dbg  = state;

endmodule

// File: tb/tb_fpu_scheduler.sv
// Bench for fpu_scheduler: one instance at latency 1 with a scoreboard on
// every response, and one at latency 4 for the mid-EXEC reset scenario.
module tb_fpu_scheduler;
  import fpu_pkg::*;

  localparam int EW = 38;  // {id, err, status[3:0], data[31:0]}

  logic             clk;
  logic             reset, reset4;

  logic [1:0]       req_valid, req_ready, rsp_valid, rsp_ready;
  logic [1:0][31:0] req_a, req_b;
  logic [1:0][1:0]  req_op;
  logic [31:0]      rsp_data, fpu_a, fpu_b, fpu_data_in;
  logic [3:0]       rsp_status, fpu_status_in;
  logic             rsp_err, busy;
  logic [1:0]       fpu_op, state_dbg;
  logic [15:0]      done_cnt;

  logic [1:0]       r4_req_valid, r4_req_ready, r4_rsp_valid, r4_rsp_ready;
  logic [1:0][31:0] r4_req_a, r4_req_b;
  logic [1:0][1:0]  r4_req_op;
  logic [31:0]      r4_rsp_data, r4_fpu_a, r4_fpu_b, r4_fpu_data_in;
  logic [3:0]       r4_rsp_status, r4_fpu_status_in;
  logic             r4_rsp_err, r4_busy;
  logic [1:0]       r4_fpu_op, r4_state_dbg;
  logic [15:0]      r4_done_cnt;

  int               n_checks = 0;
  int               n_pass   = 0;
  logic [EW-1:0]    exp_q[$];
  logic [15:0]      exp_done;
  logic             mdl_last;

  // ---------------- FPU stand-in and reference helpers ----------------
  function automatic logic [35:0] fpu_model(input logic [31:0] a, input logic [31:0] b,
                                            input logic [1:0] op);
    logic [31:0] d;
    logic [3:0]  s;
    if (op == OP_ADD && a == b) begin
      d = a + 32'h0100_0000;  // x + x: bump the exponent field
      s = 4'b0001;
    end else begin
      d = (op == OP_SUB) ? a - b : a + b;
      s = d[7:4];
    end
    return {s, d};
  endfunction

  function automatic logic [EW-1:0] make_exp(input logic id, input logic [31:0] a,
                                             input logic [31:0] b, input logic [1:0] op);
    if (op[1]) return {id, 1'b1, 4'h0, 32'h0};
    return {id, 1'b0, fpu_model(a, b, op)};
  endfunction

  function automatic logic [1:0] exp_grant(input logic [1:0] v, input logic last);
    if (v == 2'b11) return last ? 2'b01 : 2'b10;
    return v;
  endfunction

  assign {fpu_status_in, fpu_data_in}       = fpu_model(fpu_a, fpu_b, fpu_op);
  assign {r4_fpu_status_in, r4_fpu_data_in} = fpu_model(r4_fpu_a, r4_fpu_b, r4_fpu_op);

  // ---------------- DUTs ----------------
  fpu_scheduler #(.FPU_LATENCY(1)) u_dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_op(req_op),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .rsp_status(rsp_status), .rsp_err(rsp_err),
    .fpu_a(fpu_a), .fpu_b(fpu_b), .fpu_op(fpu_op),
    .fpu_data_in(fpu_data_in), .fpu_status_in(fpu_status_in),
    .busy(busy), .done_cnt(done_cnt), .state_dbg(state_dbg)
  );

  fpu_scheduler #(.FPU_LATENCY(4)) u_dut4 (
    .clk(clk), .reset(reset4),
    .req_valid(r4_req_valid), .req_ready(r4_req_ready),
    .req_a(r4_req_a), .req_b(r4_req_b), .req_op(r4_req_op),
    .rsp_valid(r4_rsp_valid), .rsp_ready(r4_rsp_ready),
    .rsp_data(r4_rsp_data), .rsp_status(r4_rsp_status), .rsp_err(r4_rsp_err),
    .fpu_a(r4_fpu_a), .fpu_b(r4_fpu_b), .fpu_op(r4_fpu_op),
    .fpu_data_in(r4_fpu_data_in), .fpu_status_in(r4_fpu_status_in),
    .busy(r4_busy), .done_cnt(r4_done_cnt), .state_dbg(r4_state_dbg)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- check task ----------------
  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic smp;
    @(negedge clk);
  endtask

  task automatic drive_req(input int idx, input logic [31:0] a, input logic [31:0] b,
                           input logic [1:0] op);
    req_a[idx]     = a;
    req_b[idx]     = b;
    req_op[idx]    = op;
    req_valid[idx] = 1'b1;
  endtask

  // Returns positioned at the negedge of the accept cycle
  task automatic wait_accept(input logic use4, input int idx);
    int  n;
    logic hit;
    n = 0;
    @(negedge clk);
    hit = use4 ? (r4_req_valid[idx] & r4_req_ready[idx]) : (req_valid[idx] & req_ready[idx]);
    while (!hit && n < 30) begin
      @(negedge clk);
      n++;
      hit = use4 ? (r4_req_valid[idx] & r4_req_ready[idx]) : (req_valid[idx] & req_ready[idx]);
    end
    chk("accept_in_time", hit, 1'b1);
  endtask

  task automatic drain;
    int n;
    req_valid = 2'b00;
    rsp_ready = 2'b11;
    n = 0;
    smp;
    while (busy && n < 50) begin
      smp;
      n++;
    end
    chk("drain_idle", busy, 1'b0);
  endtask

  // ---------------- scoreboard / monitor on the latency-1 DUT ----------------
  always @(negedge clk) begin
    if (reset) begin
      exp_q.delete();
      exp_done = 16'd0;
      mdl_last = 1'b1;
    end else begin
      if (!busy && req_valid != 2'b00)
        chk("grant", req_ready, exp_grant(req_valid, mdl_last));
      if (busy && req_valid != 2'b00)
        chk("ready_when_busy", req_ready, 2'b00);
      for (int i = 0; i < 2; i++) begin
        if (req_valid[i] && req_ready[i]) begin
          exp_q.push_back(make_exp(i[0], req_a[i], req_b[i], req_op[i]));
          mdl_last = i[0];
        end
      end
      if (rsp_valid != 2'b00) chk("rsp_onehot", $onehot(rsp_valid), 1'b1);
      for (int i = 0; i < 2; i++) begin
        if (rsp_valid[i] && rsp_ready[i]) begin
          logic [EW-1:0] e;
          chk("sb_size", exp_q.size(), 1);
          if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk("rsp_owner", i, e[37]);
            chk("rsp_err", rsp_err, e[36]);
            chk("rsp_status", rsp_status, e[35:32]);
            chk("rsp_data", rsp_data, e[31:0]);
          end
          chk("done_cnt_sb", done_cnt, exp_done);
          exp_done = exp_done + 16'd1;
        end
      end
    end
  end

  // ---------------- watchdog ----------------
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence ----------------
  logic [1:0]  g [4];
  int          ng;
  logic [31:0] hold_data;

  initial begin
    reset = 1'b1; reset4 = 1'b1;
    req_valid = '0; req_a = '0; req_b = '0; req_op = '0; rsp_ready = 2'b11;
    r4_req_valid = '0; r4_req_a = '0; r4_req_b = '0; r4_req_op = '0; r4_rsp_ready = 2'b11;

    // Reset state
    repeat (3) tick;
    smp;
    chk("rst_req_ready", req_ready, 2'b00);
    chk("rst_rsp_valid", rsp_valid, 2'b00);
    chk("rst_rsp_data", rsp_data, 32'h0);
    chk("rst_rsp_status", rsp_status, 4'h0);
    chk("rst_rsp_err", rsp_err, 1'b0);
    chk("rst_fpu_a", fpu_a, 32'h0);
    chk("rst_fpu_b", fpu_b, 32'h0);
    chk("rst_fpu_op", fpu_op, 2'b00);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done_cnt", done_cnt, 16'h0);
    tick;
    reset = 1'b0; reset4 = 1'b0;

    // Single add on requester 0, latency 1
    drive_req(0, 32'h3F00_0000, 32'h3F00_0000, OP_ADD);
    wait_accept(1'b0, 0);
    chk("t1_ready", req_ready, 2'b01);
    tick; req_valid = 2'b00;
    smp;
    chk("t1_exec_rsp_valid", rsp_valid, 2'b00);
    chk("t1_busy", busy, 1'b1);
    chk("t1_fpu_a", fpu_a, 32'h3F00_0000);
    chk("t1_fpu_op", fpu_op, OP_ADD);
    tick; smp;
    chk("t1_rsp_valid", rsp_valid, 2'b01);
    chk("t1_rsp_data", rsp_data, 32'h4000_0000);
    chk("t1_rsp_status", rsp_status, 4'b0001);
    chk("t1_rsp_err", rsp_err, 1'b0);
    tick; smp;
    chk("t1_idle", busy, 1'b0);
    chk("t1_done_cnt", done_cnt, 16'd1);

    // Illegal op on requester 1 skips EXEC
    tick;
    drive_req(1, 32'h1234_5678, 32'h0BAD_F00D, 2'b10);
    wait_accept(1'b0, 1);
    chk("t2_ready", req_ready, 2'b10);
    tick; req_valid = 2'b00;
    smp;
    chk("t2_rsp_valid", rsp_valid, 2'b10);
    chk("t2_rsp_data", rsp_data, 32'h0);
    chk("t2_rsp_status", rsp_status, 4'h0);
    chk("t2_rsp_err", rsp_err, 1'b1);
    tick; smp;
    chk("t2_done_cnt", done_cnt, 16'd2);

    // Response back-pressure with the other requester waiting
    tick;
    rsp_ready = 2'b10;
    drive_req(0, 32'h0000_0500, 32'h0000_0123, OP_SUB);
    hold_data = 32'h0000_0500 - 32'h0000_0123;
    wait_accept(1'b0, 0);
    tick;
    req_valid = 2'b00;
    drive_req(1, 32'h0000_0011, 32'h0000_0022, OP_ADD);
    smp;
    chk("t3_exec_ready", req_ready, 2'b00);
    for (int i = 0; i < 5; i++) begin
      tick; smp;
      chk("t3_hold_valid", rsp_valid, 2'b01);
      chk("t3_hold_data", rsp_data, hold_data);
      chk("t3_hold_ready", req_ready, 2'b00);
    end
    tick; rsp_ready = 2'b11;
    smp;
    chk("t3_hs_ready", req_ready, 2'b00);
    tick; smp;
    chk("t3_req1_accept", req_ready, 2'b10);
    chk("t3_done_cnt", done_cnt, 16'd3);
    tick; req_valid = 2'b00;
    tick; smp;
    chk("t3_req1_rsp", rsp_valid, 2'b10);
    tick; smp;
    chk("t3_done_cnt2", done_cnt, 16'd4);

    // Both requesters valid continuously from reset: grants alternate
    tick;
    reset = 1'b1;
    req_valid = 2'b11;
    tick;
    reset = 1'b0;
    ng = 0;
    for (int c = 0; c < 200 && ng < 4; c++) begin
      smp;
      if (req_ready != 2'b00) begin
        g[ng] = req_ready;
        ng++;
        tick;
        for (int i = 0; i < 2; i++) begin
          if (g[ng-1][i]) begin
            req_a[i]  = $urandom;
            req_b[i]  = $urandom;
            req_op[i] = 2'($urandom_range(0, 3));
          end
        end
      end else begin
        tick;
      end
    end
    chk("alt_count", ng, 4);
    chk("alt_grant0", g[0], 2'b01);
    chk("alt_grant1", g[1], 2'b10);
    chk("alt_grant2", g[2], 2'b01);
    chk("alt_grant3", g[3], 2'b10);
    drain;

    // Random traffic with random response back-pressure
    for (int c = 0; c < 300; c++) begin
      tick;
      req_valid = 2'($urandom_range(0, 3));
      rsp_ready = 2'($urandom_range(0, 3));
      for (int i = 0; i < 2; i++) begin
        req_a[i]  = $urandom;
        req_b[i]  = (($urandom_range(0, 3) == 0) ? req_a[i] : 32'($urandom));
        req_op[i] = 2'($urandom_range(0, 3));
      end
    end
    tick;
    drain;

    // Latency 4: reset in EXEC cycle 2 discards the transaction
    tick;
    r4_req_a[0] = 32'h0000_1000; r4_req_b[0] = 32'h0000_0234; r4_req_op[0] = OP_ADD;
    r4_req_valid = 2'b01;
    wait_accept(1'b1, 0);
    tick; r4_req_valid = 2'b00;
    smp;
    chk("t6_exec1_busy", r4_busy, 1'b1);
    tick; reset4 = 1'b1;
    smp;
    chk("t6_exec2_busy", r4_busy, 1'b1);
    tick; reset4 = 1'b0;
    smp;
    chk("t6_rst_busy", r4_busy, 1'b0);
    chk("t6_rst_rsp_valid", r4_rsp_valid, 2'b00);
    chk("t6_rst_rsp_data", r4_rsp_data, 32'h0);
    chk("t6_rst_rsp_status", r4_rsp_status, 4'h0);
    chk("t6_rst_rsp_err", r4_rsp_err, 1'b0);
    chk("t6_rst_fpu_a", r4_fpu_a, 32'h0);
    chk("t6_rst_fpu_b", r4_fpu_b, 32'h0);
    chk("t6_rst_fpu_op", r4_fpu_op, 2'b00);
    chk("t6_rst_done_cnt", r4_done_cnt, 16'd0);
    for (int i = 0; i < 6; i++) begin
      tick; smp;
      chk("t6_no_rsp", r4_rsp_valid, 2'b00);
    end
    chk("t6_done_after", r4_done_cnt, 16'd0);
    tick;
    r4_req_a[0] = 32'h0000_2000; r4_req_b[0] = 32'h0000_0345; r4_req_op[0] = OP_SUB;
    r4_req_valid = 2'b01;
    wait_accept(1'b1, 0);
    for (int j = 1; j <= 4; j++) begin
      tick;
      r4_req_valid = 2'b00;
      smp;
      chk("t6_exec_no_rsp", r4_rsp_valid, 2'b00);
    end
    tick; smp;
    chk("t6_rsp_valid", r4_rsp_valid, 2'b01);
    chk("t6_rsp_data", r4_rsp_data, 32'h0000_2000 - 32'h0000_0345);
    chk("t6_rsp_err", r4_rsp_err, 1'b0);
    tick; smp;
    chk("t6_done_cnt", r4_done_cnt, 16'd1);
    chk("t6_idle", r4_busy, 1'b0);

    chk("sb_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/fpu_scheduler.md
FPU_SCHEDULER -- requirements
Module: fpu_scheduler

Interface
REQ-001 SHALL have parameter FPU_LATENCY, default 1, cycles from operand drive to valid FPU result (legal range 1..15).
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port req_valid  input  2  per-requester (index 0/1) request valid.
REQ-005 SHALL have port req_ready  output  2  per-requester request accept.
REQ-006 SHALL have ports req_a, req_b  input  2x32  per-requester operands (1 sign, 7 exponent, 24 mantissa).
REQ-007 SHALL have port req_op  input  2x2  per-requester op: 00 add, 01 sub, 10/11 illegal.
REQ-008 SHALL have port rsp_valid  output  2  per-requester response valid.
REQ-009 SHALL have port rsp_ready  input  2  per-requester response accept.
REQ-010 SHALL have ports rsp_data  output  32, rsp_status  output  4 (bit0 exact, bit1 overflow, bit2 underflow, bit3 inexact), rsp_err  output  1  illegal op; shared by both requesters.
REQ-011 SHALL have ports fpu_a, fpu_b  output  32, fpu_op  output  2  drive to the shared FPU.
REQ-012 SHALL have ports fpu_data_in  input  32, fpu_status_in  input  4  results from the FPU.
REQ-013 SHALL have ports busy  output  1 (state != IDLE), done_cnt  output  16 (completed responses).

Function
REQ-014 SHALL implement FSM IDLE, EXEC, RESP; one transaction outstanding at a time.
REQ-015 IDLE: req_ready SHALL be one-hot on the granted requester, all zero if no req_valid; req_ready zero in EXEC/RESP.
REQ-016 Grant SHALL be round-robin: single valid requester wins; both valid -> requester != last_grant wins; last_grant updates on accept.
REQ-017 On accept (req_valid & req_ready), a, b, op and requester id SHALL be registered; fpu_a/fpu_b/fpu_op driven from these registers, stable until next accept.
REQ-018 Legal op accepted in cycle k: EXEC for cycles k+1..k+FPU_LATENCY via down-counter; fpu_data_in/fpu_status_in captured at end of cycle k+FPU_LATENCY; rsp_valid asserted from cycle k+FPU_LATENCY+1.
REQ-019 Illegal op SHALL skip EXEC: RESP from cycle k+1 with rsp_data=0, rsp_status=0, rsp_err=1.
REQ-020 RESP: rsp_valid[id]=1 only for the owning requester; rsp_data/status/err held stable until rsp_ready[id]; other requester's rsp_ready ignored.
REQ-021 On response handshake, SHALL return to IDLE next cycle and increment done_cnt (wraps 0xFFFF->0x0000); a new accept is possible in that IDLE cycle.
REQ-022 rsp_err SHALL be 0 for every legal op; rsp_status passed through unmodified.
REQ-023 req_valid dropping while not granted SHALL be tolerated (no state change).

Reset
REQ-024 reset SHALL force IDLE, last_grant=1 (requester 0 wins first tie), counter=0, done_cnt=0, all outputs 0 (req_ready, rsp_valid, rsp_data, rsp_status, rsp_err, fpu_a, fpu_b, fpu_op, busy).
REQ-025 reset asserted mid EXEC/RESP SHALL discard the transaction with no response and no done_cnt increment; reset dominates simultaneous handshakes.

Structure
REQ-026 Shared package fpu_pkg SHALL hold EXP_WIDTH=7, MANT_WIDTH=24, op codes (OP_ADD, OP_SUB), status bit indices, and the scheduler state enum.
REQ-027 Round-robin grant logic SHALL be a sub-module rr_arb2 (inputs req[1:0], last_grant; output one-hot grant); the FPU itself is external.

Verification
REQ-028 Single req0 add a=0x3F000000, b=0x3F000000, FPU_LATENCY=1, model returns 0x40000000/status 0001 -> rsp_valid[0] two cycles after accept, rsp_data=0x40000000, rsp_status=0001, rsp_err=0, done_cnt=1.
REQ-029 Both requesters valid continuously from reset -> grants alternate 0,1,0,1; each response routed only to its owner.
REQ-030 req1 op=2'b10 -> rsp_valid[1] one cycle after accept, rsp_data=0, rsp_status=0, rsp_err=1, FPU result ignored.
REQ-031 rsp_ready[0] held low 5 cycles in RESP, req1 valid -> rsp outputs stable, req_ready[1]=0 until handshake, then req1 accepted next cycle.
REQ-032 FPU_LATENCY=4, reset pulsed in EXEC cycle 2 -> all outputs 0, no rsp_valid, done_cnt unchanged at 0; next request completes normally.
